// File: rtl/gate_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_chk_pkg
// Description : Shared types and truth-table constants for gate_resp_checker.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } chk_state_t;

    // Expected y indexed by {a2,a1}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage
`default_nettype wire

// File: rtl/gate_resp_checker_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/gate_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_resp_checker
// Description : Checks a two-input cell's output against a programmable truth
//               table after a settle delay; tracks counts, coverage, 1st fail.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       truth_tbl,
    input  logic             vec_valid,
    input  logic             a1,
    input  logic             a2,
    input  logic             y,
    output logic             vec_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic             first_fail_vld,
    output logic [1:0]       first_fail_vec
);

    localparam logic [3:0] c_settle_load = 4'(SETTLE - 1);

    chk_state_t  r_state;
    chk_state_t  w_state_next;
    logic [3:0]  r_tt;
    logic [1:0]  r_idx;
    logic        r_exp;
    logic [3:0]  r_cnt;
    logic [3:0]  r_cov;
    logic        r_ff_vld;
    logic [1:0]  r_ff_vec;

    logic [1:0]  w_idx;
    logic        w_accept;
    logic        w_sample;
    logic        w_mismatch;
    logic [3:0]  w_cov_next;

    assign w_idx      = {a2, a1};
    assign w_accept   = vec_valid && (r_state == ST_ARMED) && !start;
    // A sample coinciding with start is dropped: start wins
    assign w_sample   = (r_state == ST_SETTLE) && (r_cnt == 4'd0) && !start;
    assign w_mismatch = (y != r_exp);
    assign w_cov_next = r_cov | (4'b0001 << r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED:  if (vec_valid) w_state_next = ST_SETTLE;
                ST_SETTLE: if (r_cnt == 4'd0)
                               w_state_next = (w_cov_next == 4'hF) ? ST_DONE : ST_ARMED;
                default:   w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tt     <= 4'd0;
            r_idx    <= 2'd0;
            r_exp    <= 1'b0;
            r_cnt    <= 4'd0;
            r_cov    <= 4'd0;
            r_ff_vld <= 1'b0;
            r_ff_vec <= 2'd0;
        end else if (start) begin
            r_tt     <= truth_tbl;
            r_idx    <= 2'd0;
            r_exp    <= 1'b0;
            r_cnt    <= 4'd0;
            r_cov    <= 4'd0;
            r_ff_vld <= 1'b0;
            r_ff_vec <= 2'd0;
        end else begin
            if (w_accept) begin
                r_idx <= w_idx;
                r_exp <= r_tt[w_idx];
                r_cnt <= c_settle_load;
            end else if ((r_state == ST_SETTLE) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_sample) begin
                r_cov <= w_cov_next;
                if (w_mismatch && !r_ff_vld) begin
                    r_ff_vld <= 1'b1;
                    r_ff_vec <= r_idx;
                end
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_chk_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (w_sample),
        .cnt   (chk_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (w_sample && w_mismatch),
        .cnt   (err_cnt)
    );

    assign vec_ready      = (r_state == ST_ARMED);
    assign busy           = (r_state == ST_ARMED) || (r_state == ST_SETTLE);
    assign done           = (r_state == ST_DONE);
    assign pass           = (r_state == ST_DONE) && (err_cnt == '0);
    assign cov            = r_cov;
    assign first_fail_vld = r_ff_vld;
    assign first_fail_vec = r_ff_vec;

endmodule
`default_nettype wire

// File: tb/tb_gate_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_resp_checker
// Description : Self-checking bench for gate_resp_checker against a
//               cycle-level behavioural model, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_resp_checker;
    import gate_chk_pkg::*;

    localparam int SETTLE = 2;
    localparam int CNT_W  = 8;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       truth_tbl = 4'd0;
    logic             vec_valid = 1'b0;
    logic             a1 = 1'b0;
    logic             a2 = 1'b0;
    logic             y = 1'b0;
    logic             vec_ready, busy, done, pass;
    logic [CNT_W-1:0] chk_cnt, err_cnt;
    logic [3:0]       cov;
    logic             first_fail_vld;
    logic [1:0]       first_fail_vec;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit sim_end = 1'b0;

    gate_resp_checker #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .truth_tbl      (truth_tbl),
        .vec_valid      (vec_valid),
        .a1             (a1),
        .a2             (a2),
        .y              (y),
        .vec_ready      (vec_ready),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .chk_cnt        (chk_cnt),
        .err_cnt        (err_cnt),
        .cov            (cov),
        .first_fail_vld (first_fail_vld),
        .first_fail_vec (first_fail_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit       m_active, m_done, m_pend, m_ffv;
    int       m_left, m_chk, m_err;
    logic [3:0] m_tt, m_cov;
    logic [1:0] m_idx, m_ffvec;
    logic       m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_pend = 0; m_left = 0;
            m_chk = 0; m_err = 0; m_cov = 0; m_ffv = 0; m_ffvec = 0; m_tt = 0;
        end else if (start) begin
            m_tt = truth_tbl; m_active = 1; m_done = 0; m_pend = 0;
            m_chk = 0; m_err = 0; m_cov = 0; m_ffv = 0; m_ffvec = 0;
        end else if (m_active && !m_done) begin
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    m_pend = 0;
                    m_chk++;
                    if (y !== m_exp) begin
                        m_err++;
                        if (!m_ffv) begin m_ffv = 1; m_ffvec = m_idx; end
                    end
                    m_cov[m_idx] = 1'b1;
                    if (m_cov == 4'hF) m_done = 1;
                end
            end else if (vec_valid) begin
                m_pend = 1;
                m_left = SETTLE;
                m_idx  = {a2, a1};
                m_exp  = m_tt[m_idx];
            end
        end
    end

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    always @(negedge clk) begin
        if (!sim_end) begin
            check("vec_ready", vec_ready, m_active && !m_done && !m_pend);
            check("busy", busy, m_active && !m_done);
            check("done", done, m_done);
            check("pass", pass, m_done && (m_err == 0));
            check("chk_cnt", chk_cnt, sat(m_chk));
            check("err_cnt", err_cnt, sat(m_err));
            check("cov", cov, m_cov);
            check("ff_vld", first_fail_vld, m_ffv);
            check("ff_vec", first_fail_vec, m_ffvec);
        end
    end

    // ---------------- stimulus helpers (entered at a negedge) ----------------
    task automatic do_start(input logic [3:0] tt);
        truth_tbl = tt; start = 1'b1; vec_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(output int acc);
        int t = 0;
        while (!vec_ready && t < 100) begin @(negedge clk); t++; end
        check("ready_timeout", (t < 100), 1);
        acc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic send_vec(input logic [1:0] v, input logic yv, input bit hold, output int acc);
        a1 = v[0]; a2 = v[1]; y = yv; vec_valid = 1'b1;
        wait_ready(acc);
        if (!hold) vec_valid = 1'b0;
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic send_abort(input logic [1:0] v, input logic yv, input int k, input logic [3:0] ntt);
        int acc;
        a1 = v[0]; a2 = v[1]; y = yv; vec_valid = 1'b1;
        wait_ready(acc);
        repeat (k - 1) @(negedge clk);
        do_start(ntt);
    endtask

    function automatic logic [23:0] all_out();
        return {vec_ready, busy, done, pass, chk_cnt, err_cnt, cov, first_fail_vld, first_fail_vec};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int acc, first_acc;
        logic [3:0] tt;
        logic [3:0] tts [5];
        logic [1:0] v;
        tts[0] = TT_AND; tts[1] = TT_OR; tts[2] = TT_NAND; tts[3] = TT_NOR; tts[4] = TT_XOR;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_out(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", vec_ready, 0);

        // correct AND
        tt = TT_AND;
        do_start(tt);
        check("armed_ready", vec_ready, 1);
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            send_vec(v, tt[v], 1'b0, acc);
            if (i == 0) first_acc = acc;
        end
        check("and_done", done, 1);
        check("and_pass", pass, 1);
        check("and_chk", chk_cnt, 4);
        check("and_err", err_cnt, 0);
        check("and_cov", cov, 4'hF);
        check("and_latency", cyc - first_acc, 11);
        repeat (3) @(negedge clk);
        check("done_held", done, 1);

        // stuck-at-0
        do_start(TT_AND);
        for (int i = 0; i < 4; i++) send_vec(2'(i), 1'b0, 1'b0, acc);
        check("sa0_err", err_cnt, 1);
        check("sa0_ffv", first_fail_vld, 1);
        check("sa0_ffvec", first_fail_vec, 2'b11);
        check("sa0_pass", pass, 0);

        // repeats with valid held
        tt = TT_XOR;
        do_start(tt);
        for (int i = 0; i < 5; i++) begin
            v = (i == 0) ? 2'd0 : 2'(i - 1);
            send_vec(v, tt[v], 1'b1, acc);
            if (i == 0) first_acc = acc;
            if (i == 3) check("rep_not_done", done, 0);
        end
        check("rep_chk", chk_cnt, 5);
        check("rep_done", done, 1);
        check("rep_latency", cyc - first_acc, 14);

        // saturation with inverted y on OR
        tt = TT_OR;
        do_start(tt);
        for (int i = 0; i < 260; i++) send_vec(2'd0, ~tt[0], $urandom_range(0, 1), acc);
        for (int i = 1; i < 4; i++) begin
            v = 2'(i);
            send_vec(v, ~tt[v], 1'b0, acc);
        end
        check("sat_chk", chk_cnt, MAXC);
        check("sat_err", err_cnt, MAXC);
        check("sat_done", done, 1);

        // start during SETTLE
        do_start(TT_AND);
        send_abort(2'd3, 1'b1, 1, TT_NOR);
        check("abort_chk", chk_cnt, 0);
        check("abort_cov", cov, 0);
        check("abort_ready", vec_ready, 1);
        repeat (2) @(negedge clk);
        check("abort_no_sample", chk_cnt, 0);
        tt = TT_NOR;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            send_vec(v, tt[v], 1'b0, acc);
        end
        check("nor_pass", pass, 1);

        // reset mid-SETTLE
        do_start(TT_AND);
        a1 = 1'b1; a2 = 1'b0; vec_valid = 1'b1;
        wait_ready(acc);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", all_out(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_ready", vec_ready, 0);

        // randomized runs
        for (int it = 0; it < 25; it++) begin
            tt = ($urandom_range(0, 1) == 0) ? tts[$urandom_range(0, 4)] : 4'($urandom);
            do_start(tt);
            for (int k = 0; k < 40 && !m_done; k++) begin
                v = 2'($urandom);
                vec_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if ($urandom_range(0, 9) == 0) begin
                    tt = 4'($urandom);
                    send_abort(v, m_tt[v] ^ ($urandom_range(0, 4) == 0), $urandom_range(1, SETTLE), tt);
                end else begin
                    send_vec(v, m_tt[v] ^ ($urandom_range(0, 4) == 0), $urandom_range(0, 1), acc);
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        sim_end = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
